chan_seq_scheduler: RTL and testbench
=====================================

# chan_seq_scheduler

Capture scheduler for the multi-channel sample shift buffers. Paces sample capture with a programmable interval timer and steps round-robin through the enabled channels. Each capture issues a one-hot shift strobe to exactly one channel buffer. The block counts completed sweeps and flags a full frame once every enabled channel holds DEPTH fresh samples.

## Interface
Parameters:
- NUM_CHANNELS, 7, number of channel buffers (1..16)
- DEPTH, 10, samples per channel buffer, i.e. sweeps per frame (2..255)
- PERIOD_W, 16, width of the capture interval input

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to begin a frame
- stop  in  1  abort; return to idle
- chan_mask  in  NUM_CHANNELS  enabled channels, latched on accepted start
- period  in  PERIOD_W  capture interval in cycles, latched on accepted start
- shift_en  out  NUM_CHANNELS  one-hot shift strobe to the selected buffer
- cur_chan  out  $clog2(NUM_CHANNELS)  index of the channel last or currently strobed
- sweep_cnt  out  $clog2(DEPTH)  completed sweeps in the current frame
- busy  out  1  high in WAIT or CAPTURE
- frame_done  out  1  pulse, coincident with the final capture of a frame
- frame_ready  out  1  level, high in DONE
- start_err  out  1  pulse; start rejected because the mask was zero

## Operation
- States:
  - IDLE: wait for start.
  - WAIT: interval timer running.
  - CAPTURE: exactly one cycle; the selected buffer shifts.
  - DONE: frame complete; present only without the continuous macro.
- Reset: state IDLE. All outputs, cur_chan, sweep_cnt, the timer and the latched mask/period are 0.
- IDLE + start with chan_mask != 0:
  - latch mask and effective period P = max(period, 2)
  - set cur_chan to the lowest set mask bit and sweep_cnt to 0
  - go to WAIT with the timer loaded to P-2
- IDLE + start with chan_mask == 0: pulse start_err for one cycle and stay in IDLE.
- WAIT: decrement the timer. When timer == 0, go to CAPTURE.
- CAPTURE:
  - shift_en = 1 << cur_chan, a Moore output for this cycle only
  - compute the next channel: the next set mask bit above cur_chan, wrapping to the lowest set bit
  - the sweep ends if the next channel is ≤ cur_chan; this includes the single-channel case
  - sweep ends with sweep_cnt < DEPTH-1: increment sweep_cnt
  - sweep ends with sweep_cnt == DEPTH-1: frame_done = 1 this cycle, then apply the frame-end rule under Configuration
  - otherwise cur_chan advances to the next channel and the block returns to WAIT with the timer reloaded to P-2
- stop is honoured in any non-IDLE state and returns the block to IDLE next cycle:
  - stop in WAIT: no strobe is issued
  - stop in CAPTURE: that cycle's strobe still completes
  - stop + start in the same cycle: stop wins
- start outside IDLE/DONE is ignored. start in DONE behaves as in IDLE.
- chan_mask and period changes after the start is latched have no effect until the next start.

## Timing
- Start accepted at cycle t: first CAPTURE at t+P. Later captures every P cycles.
- Frame length: DEPTH × popcount(mask) captures, i.e. DEPTH × popcount(mask) × P cycles from start to the last strobe.
- Never more than one shift_en bit high in any cycle. shift_en is 0 outside CAPTURE.
- busy falls one cycle after the last CAPTURE in single-frame mode, or one cycle after stop.
- Reset mid-frame: everything returns to its reset value next cycle. No further strobes.

## Configuration
- Macro CHAN_SEQ_CONTINUOUS_EN.
- Defined:
  - after frame_done, sweep_cnt wraps to 0 and cur_chan goes to the lowest set bit
  - the block returns to WAIT and keeps capturing; the buffers act as a rolling window
  - frame_done pulses once per frame; DONE is unreachable and frame_ready stays 0
- Undefined:
  - after frame_done the block enters DONE; busy = 0 and frame_ready = 1
  - frame_ready holds until an accepted start, stop, or reset

## Structure
- Package chan_seq_pkg holds:
  - the state enum (IDLE, WAIT, CAPTURE, DONE)
  - the width constants CHAN_IDX_W = $clog2(NUM_CHANNELS) and SWEEP_W = $clog2(DEPTH)
  - the minimum-period constant MIN_PERIOD = 2
- Sub-module chan_seq_next_sel, combinational:
  - inputs: mask, current index
  - outputs: next set index with wrap, and a wrapped flag
- Top level holds the FSM, the timer and the counters.

## Test plan
- Reset hold, then release: every output is 0 and no strobe appears for 50 cycles.
- mask=7'b0000101, period=4, DEPTH=10:
  - strobes alternate 0x01 and 0x04, one every 4 cycles, first at t+4
  - frame_done pulses with the 20th strobe
- period=0 and period=1: both yield a 2-cycle capture interval.
- start with mask=0: start_err pulses once, busy stays 0, no strobes.
- stop issued during WAIT after 7 captures: no 8th strobe, busy falls next cycle, sweep_cnt resets on the next start.
- Single-channel mask 7'b1000000, period=3:
  - sweep_cnt increments on every strobe
  - frame_done comes after 10 strobes
  - with CHAN_SEQ_CONTINUOUS_EN, a second frame_done follows 30 cycles later

Source files
------------

// File: rtl/chan_seq_pkg.sv
// Shared types and constants for the channel capture scheduler.
// Optional feature macro: CHAN_SEQ_CONTINUOUS_EN (rolling-window capture).
package chan_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int NUM_CHANNELS_DEF = 7;
    localparam int DEPTH_DEF        = 10;
    localparam int CHAN_IDX_W       = $clog2(NUM_CHANNELS_DEF);
    localparam int SWEEP_W          = $clog2(DEPTH_DEF);
    localparam int MIN_PERIOD       = 2;

    // Width of an index/count field; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the lowest set bit of a mask of up to 16 channels.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/chan_seq_scheduler_if.sv
// Control and strobe bundle between a frame controller and the capture scheduler.
interface chan_seq_scheduler_if #(
    parameter int NUM_CHANNELS = 7,
    parameter int DEPTH        = 10,
    parameter int PERIOD_W     = 16
);
    localparam int IW = chan_seq_pkg::width_of(NUM_CHANNELS);
    localparam int SW = chan_seq_pkg::width_of(DEPTH);

    logic                    start;
    logic                    stop;
    logic [NUM_CHANNELS-1:0] chan_mask;
    logic [PERIOD_W-1:0]     period;
    logic [NUM_CHANNELS-1:0] shift_en;
    logic [IW-1:0]           cur_chan;
    logic [SW-1:0]           sweep_cnt;
    logic                    busy;
    logic                    frame_done;
    logic                    frame_ready;
    logic                    start_err;

    modport master (
        output start, stop, chan_mask, period,
        input  shift_en, cur_chan, sweep_cnt, busy, frame_done, frame_ready, start_err
    );

    modport slave (
        input  start, stop, chan_mask, period,
        output shift_en, cur_chan, sweep_cnt, busy, frame_done, frame_ready, start_err
    );

endinterface

// File: rtl/chan_seq_next_sel.sv
// Round-robin selector: next enabled channel above the current one, wrapping to the lowest.
module chan_seq_next_sel
    import chan_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 7,
    parameter int IDX_W        = width_of(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] mask_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [IDX_W-1:0]        next_idx_o,
    output logic                    wrapped_o
);

    logic             found_above;
    logic [IDX_W-1:0] above_idx;
    logic [IDX_W-1:0] lowest_idx;

    // Scan from the top so the last hit is the lowest candidate in each class.
    always_comb begin
        found_above = 1'b0;
        above_idx   = '0;
        lowest_idx  = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_idx = IDX_W'(i);
                if (i > int'(idx_i)) begin
                    above_idx   = IDX_W'(i);
                    found_above = 1'b1;
                end
            end
        end
        next_idx_o = found_above ? above_idx : lowest_idx;
        wrapped_o  = ~found_above;
    end

endmodule

// File: rtl/chan_seq_scheduler.sv
// Capture scheduler: paces one-hot shift strobes round-robin over enabled channels.
// Optional macro CHAN_SEQ_CONTINUOUS_EN: keep capturing after each frame instead of stopping in DONE.
module chan_seq_scheduler
    import chan_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = 7,
    parameter int DEPTH        = 10,
    parameter int PERIOD_W     = 16
) (
    input logic                 clk,
    input logic                 reset,
    chan_seq_scheduler_if.slave sched_io
);

    localparam int IW = width_of(NUM_CHANNELS);
    localparam int SW = width_of(DEPTH);

    state_e                  state_q, state_d;
    logic [PERIOD_W-1:0]     timer_q, timer_d;
    logic [PERIOD_W-1:0]     reload_q, reload_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [IW-1:0]           cur_q, cur_d;
    logic [SW-1:0]           sweep_q, sweep_d;
    logic                    start_err_q, start_err_d;

    logic [IW-1:0]           next_idx;
    logic                    wrapped;
    logic [IW-1:0]           first_idx;
    logic [PERIOD_W-1:0]     eff_period;
    logic                    frame_end;

    chan_seq_next_sel #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .IDX_W       (IW)
    ) u_next_sel (
        .mask_i    (mask_q),
        .idx_i     (cur_q),
        .next_idx_o(next_idx),
        .wrapped_o (wrapped)
    );

    assign first_idx  = IW'(lowest_set(16'(sched_io.chan_mask)));
    assign eff_period = (sched_io.period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                   : sched_io.period;
    assign frame_end  = wrapped && (sweep_q == SW'(DEPTH - 1));

    // Next-state logic: start/stop handling, interval countdown, channel and sweep stepping.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        reload_d    = reload_q;
        mask_d      = mask_q;
        cur_d       = cur_q;
        sweep_d     = sweep_q;
        start_err_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && sched_io.stop) begin
                    state_d = IDLE;
                end else if (sched_io.start) begin
                    if (sched_io.chan_mask != '0) begin
                        mask_d   = sched_io.chan_mask;
                        reload_d = eff_period - PERIOD_W'(MIN_PERIOD);
                        timer_d  = eff_period - PERIOD_W'(MIN_PERIOD);
                        cur_d    = first_idx;
                        sweep_d  = '0;
                        state_d  = WAIT;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (sched_io.stop) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    timer_d = timer_q - PERIOD_W'(1);
                end
            end
            CAPTURE: begin
                if (sched_io.stop) begin
                    state_d = IDLE;
                end else if (frame_end) begin
`ifdef CHAN_SEQ_CONTINUOUS_EN
                    sweep_d = '0;
                    cur_d   = next_idx;
                    timer_d = reload_q;
                    state_d = WAIT;
`else
                    state_d = DONE;
`endif
                end else begin
                    if (wrapped) begin
                        sweep_d = sweep_q + SW'(1);
                    end
                    cur_d   = next_idx;
                    timer_d = reload_q;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            reload_q    <= '0;
            mask_q      <= '0;
            cur_q       <= '0;
            sweep_q     <= '0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            reload_q    <= reload_d;
            mask_q      <= mask_d;
            cur_q       <= cur_d;
            sweep_q     <= sweep_d;
            start_err_q <= start_err_d;
        end
    end

    assign sched_io.shift_en    = (state_q == CAPTURE) ? (NUM_CHANNELS'(1) << cur_q) : '0;
    assign sched_io.cur_chan    = cur_q;
    assign sched_io.sweep_cnt   = sweep_q;
    assign sched_io.busy        = (state_q == WAIT) || (state_q == CAPTURE);
    assign sched_io.frame_done  = (state_q == CAPTURE) && frame_end;
    assign sched_io.frame_ready = (state_q == DONE);
    assign sched_io.start_err   = start_err_q;

endmodule

// File: tb/tb_chan_seq_scheduler.sv
// Self-checking bench for chan_seq_scheduler: table-driven frames, corner sequences, random run.
module tb_chan_seq_scheduler;
    localparam int NUM_CHANNELS = 7;
    localparam int DEPTH        = 10;
    localparam int PERIOD_W     = 16;
    localparam int LIMIT        = 400;

    logic clk;
    logic reset;

    chan_seq_scheduler_if #(.NUM_CHANNELS(NUM_CHANNELS), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) bus ();

    chan_seq_scheduler #(.NUM_CHANNELS(NUM_CHANNELS), .DEPTH(DEPTH), .PERIOD_W(PERIOD_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .sched_io(bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;

    bit mActive, mDone, mErr;
    int mP, mPos, mSweep, mCur, mCapAt;
    int mOrder[$];

    logic [6:0] obsShift;
    logic       obsBusy, obsDone, obsReady, obsErr;
    logic [3:0] obsSweep;

    typedef struct {
        logic [6:0]  mask;
        logic [15:0] period;
        int          expP;
        logic [6:0]  expFirst;
        logic [6:0]  expSecond;
        int          expStrobes;
    } vec_t;
    vec_t vecs[5];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    function automatic bit modelCapture();
        return mActive && (cyc == mCapAt);
    endfunction

    // Compare every DUT output against the reference model for the current cycle.
    task automatic checkOutput();
        logic [6:0] expShift;
        bit cap;
        cap      = modelCapture();
        expShift = cap ? 7'(1 << mCur) : 7'd0;
        obsShift = bus.shift_en;
        obsBusy  = bus.busy;
        obsDone  = bus.frame_done;
        obsReady = bus.frame_ready;
        obsErr   = bus.start_err;
        obsSweep = bus.sweep_cnt;
        cmp("shift_en", 32'(bus.shift_en), 32'(expShift));
        cmp("onehot", 32'($onehot0(bus.shift_en)), 32'd1);
        cmp("cur_chan", 32'(bus.cur_chan), 32'(mCur));
        cmp("sweep_cnt", 32'(bus.sweep_cnt), 32'(mSweep));
        cmp("busy", 32'(bus.busy), 32'(mActive));
        cmp("frame_done", 32'(bus.frame_done),
            32'(cap && (mPos == mOrder.size() - 1) && (mSweep == DEPTH - 1)));
        cmp("frame_ready", 32'(bus.frame_ready), 32'(mDone));
        cmp("start_err", 32'(bus.start_err), 32'(mErr));
    endtask

    // Advance the reference model by one cycle given this cycle's inputs.
    task automatic modelStep(input bit st, input bit sp, input logic [6:0] m,
                             input logic [15:0] p, input bit rst);
        bit cap;
        bit errNext;
        cap     = modelCapture();
        errNext = 1'b0;
        if (rst) begin
            mActive = 0; mDone = 0; mCur = 0; mSweep = 0; mPos = 0;
        end else if (mActive) begin
            if (sp) begin
                mActive = 0;
            end else if (cap) begin
                if (mPos == mOrder.size() - 1) begin
                    if (mSweep == DEPTH - 1) begin
`ifdef CHAN_SEQ_CONTINUOUS_EN
                        mSweep = 0; mPos = 0; mCur = mOrder[0]; mCapAt = cyc + mP;
`else
                        mActive = 0; mDone = 1;
`endif
                    end else begin
                        mSweep++; mPos = 0; mCur = mOrder[0]; mCapAt = cyc + mP;
                    end
                end else begin
                    mPos++; mCur = mOrder[mPos]; mCapAt = cyc + mP;
                end
            end
        end else if (mDone && sp) begin
            mDone = 0;
        end else if (st) begin
            if (m != 0) begin
                mOrder.delete();
                for (int i = 0; i < NUM_CHANNELS; i++) if (m[i]) mOrder.push_back(i);
                mP      = (p < 2) ? 2 : int'(p);
                mPos    = 0;
                mCur    = mOrder[0];
                mSweep  = 0;
                mActive = 1;
                mDone   = 0;
                mCapAt  = cyc + mP;
            end else begin
                errNext = 1'b1;
            end
        end
        mErr = errNext;
    endtask

    // One cycle: check outputs, drive this cycle's inputs, step the model.
    task automatic applyStimulus(input bit st, input bit sp, input logic [6:0] m,
                                 input logic [15:0] p, input bit rst);
        @(negedge clk);
        checkOutput();
        bus.start     = st;
        bus.stop      = sp;
        bus.chan_mask = m;
        bus.period    = p;
        reset         = rst;
        modelStep(st, sp, m, p, rst);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 7'(0), 16'(0), 0);
    endtask

    int nStrobes, firstAt, secondAt, lastAt, doneAt, doneStrobe;
    logic [6:0] firstShift, secondShift;

    initial begin
        reset = 1'b1; bus.start = 0; bus.stop = 0; bus.chan_mask = '0; bus.period = '0;
        mActive = 0; mDone = 0; mErr = 0; mCur = 0; mSweep = 0; mPos = 0; mP = 2; mCapAt = 0;
        vecs[0] = '{7'b0000101, 16'd4, 4, 7'h01, 7'h04, 20};
        vecs[1] = '{7'b0000101, 16'd0, 2, 7'h01, 7'h04, 20};
        vecs[2] = '{7'b0000101, 16'd1, 2, 7'h01, 7'h04, 20};
        vecs[3] = '{7'b1000000, 16'd3, 3, 7'h40, 7'h40, 10};
        vecs[4] = '{7'b0110010, 16'd5, 5, 7'h02, 7'h10, 30};
        repeat (2) @(posedge clk);

        $display("[TB] reset hold and idle");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 7'h7f, 16'd3, 1);
        nStrobes = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
            if (obsShift != 0) nStrobes++;
        end
        cmp("idle_strobes", 32'(nStrobes), 32'd0);

        $display("[TB] table-driven frames");
        for (int v = 0; v < 5; v++) begin
            nStrobes = 0; firstAt = 0; secondAt = 0; lastAt = 0; doneAt = 0; doneStrobe = 0;
            firstShift = 0; secondShift = 0;
            applyStimulus(1, 0, vecs[v].mask, vecs[v].period, 0);
            for (int k = 1; k <= LIMIT && doneAt == 0; k++) begin
                applyStimulus(0, 0, 7'($urandom), 16'($urandom_range(0, 9)), 0);
                if (obsShift != 0) begin
                    nStrobes++;
                    if (nStrobes == 1) begin firstAt = k; firstShift = obsShift; end
                    if (nStrobes == 2) begin secondAt = k; secondShift = obsShift; end
                    lastAt = k;
                end
                if (obsDone) begin doneAt = k; doneStrobe = nStrobes; end
            end
            cmp("frame_done_seen", 32'(doneAt != 0), 32'd1);
            cmp("first_at", 32'(firstAt), 32'(vecs[v].expP));
            cmp("first_shift", 32'(firstShift), 32'(vecs[v].expFirst));
            cmp("interval", 32'(secondAt - firstAt), 32'(vecs[v].expP));
            cmp("second_shift", 32'(secondShift), 32'(vecs[v].expSecond));
            cmp("done_strobe", 32'(doneStrobe), 32'(vecs[v].expStrobes));
            cmp("last_at", 32'(lastAt), 32'(vecs[v].expStrobes * vecs[v].expP));
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
`ifdef CHAN_SEQ_CONTINUOUS_EN
            cmp("post_busy", 32'(obsBusy), 32'd1);
            cmp("post_ready", 32'(obsReady), 32'd0);
            applyStimulus(0, 1, 7'(0), 16'(0), 0);
            idle(1);
`else
            cmp("post_busy", 32'(obsBusy), 32'd0);
            cmp("post_ready", 32'(obsReady), 32'd1);
`endif
        end
        applyStimulus(0, 1, 7'(0), 16'(0), 0);
        idle(2);

        $display("[TB] zero-mask start");
        applyStimulus(1, 0, 7'(0), 16'd3, 0);
        applyStimulus(0, 0, 7'(0), 16'd3, 0);
        cmp("err_pulse", 32'(obsErr), 32'd1);
        cmp("err_busy", 32'(obsBusy), 32'd0);
        nStrobes = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
            if (obsShift != 0 || obsErr) nStrobes++;
        end
        cmp("err_quiet", 32'(nStrobes), 32'd0);

        $display("[TB] stop in WAIT after 7 captures");
        nStrobes = 0;
        applyStimulus(1, 0, 7'b0000101, 16'd4, 0);
        for (int k = 0; k < LIMIT && nStrobes < 7; k++) begin
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
            if (obsShift != 0) nStrobes++;
        end
        cmp("seven_strobes", 32'(nStrobes), 32'd7);
        applyStimulus(0, 1, 7'(0), 16'(0), 0);
        cmp("stop_busy_before", 32'(obsBusy), 32'd1);
        cmp("stop_sweep", 32'(obsSweep), 32'd3);
        applyStimulus(0, 0, 7'(0), 16'(0), 0);
        cmp("stop_busy_after", 32'(obsBusy), 32'd0);
        nStrobes = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
            if (obsShift != 0) nStrobes++;
        end
        cmp("no_eighth", 32'(nStrobes), 32'd0);
        applyStimulus(1, 0, 7'b0000101, 16'd4, 0);
        applyStimulus(0, 0, 7'(0), 16'(0), 0);
        cmp("restart_sweep", 32'(obsSweep), 32'd0);
        cmp("restart_busy", 32'(obsBusy), 32'd1);
        applyStimulus(1, 1, 7'b0000011, 16'd2, 0);
        applyStimulus(0, 0, 7'(0), 16'(0), 0);
        cmp("stop_wins", 32'(obsBusy), 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 0, 7'b0101010, 16'd2, 0);
        idle(9);
        applyStimulus(0, 0, 7'(0), 16'(0), 1);
        applyStimulus(0, 0, 7'(0), 16'(0), 0);
        cmp("rst_busy", 32'(obsBusy), 32'd0);
        nStrobes = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
            if (obsShift != 0) nStrobes++;
        end
        cmp("rst_quiet", 32'(nStrobes), 32'd0);

`ifdef CHAN_SEQ_CONTINUOUS_EN
        $display("[TB] continuous single channel");
        firstAt = 0; secondAt = 0;
        applyStimulus(1, 0, 7'b1000000, 16'd3, 0);
        for (int k = 1; k <= LIMIT && secondAt == 0; k++) begin
            applyStimulus(0, 0, 7'(0), 16'(0), 0);
            if (obsDone) begin
                if (firstAt == 0) firstAt = k;
                else secondAt = k;
            end
        end
        cmp("cont_first_done", 32'(firstAt), 32'd30);
        cmp("cont_gap", 32'(secondAt - firstAt), 32'd30);
        applyStimulus(0, 1, 7'(0), 16'(0), 0);
        idle(1);
`endif

        $display("[TB] random run");
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] rm;
            rm = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0, rm,
                          16'($urandom_range(0, 6)), $urandom_range(0, 799) == 0);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
